// File: rtl/hmmm_mem_responder_if.sv
// Core bus and host boot-link signals between the HMMM core/host side and the memory responder.
// The master drives requests and load bytes; the slave (responder) answers with read data and holds.
interface hmmm_mem_responder_if #(
    parameter int unsigned AddrWidth = 8
);
    logic                 cpu_memwrite;
    logic [AddrWidth-1:0] cpu_adr;
    logic [7:0]           cpu_wdata;
    logic [14:0]          cpu_rdata;
    logic                 cpu_hold;

    logic                 ld_valid;
    logic [7:0]           ld_data;
    logic                 ld_last;
    logic                 ld_ready;

    modport master (
        output cpu_memwrite, cpu_adr, cpu_wdata, ld_valid, ld_data, ld_last,
        input  cpu_rdata, cpu_hold, ld_ready
    );

    modport slave (
        input  cpu_memwrite, cpu_adr, cpu_wdata, ld_valid, ld_data, ld_last,
        output cpu_rdata, cpu_hold, ld_ready
    );
endinterface

// File: rtl/hmmm_mem_responder.sv
// Memory-side end of the HMMM bus: boot-loads an async 256x16 SRAM from a byte link, then serves
// core reads/writes to it, with one address decoded as an I/O register.
module hmmm_mem_responder #(
    parameter int unsigned          AddrWidth = 8,
    parameter logic [AddrWidth-1:0] IoAddr    = {AddrWidth{1'b1}},
    parameter bit                   BootEn    = 1'b1
) (
    input  logic                 ph1_i,
    input  logic                 ph2_i,
    input  logic                 reset_i,

    hmmm_mem_responder_if.slave  bus,

    output logic                 sram_ce_n_o,
    output logic                 sram_oe_n_o,
    output logic                 sram_we_n_o,
    output logic [AddrWidth-1:0] sram_adr_o,
    output logic [15:0]          sram_wdata_o,
    output logic                 sram_wdata_oe_o,
    input  logic [15:0]          sram_rdata_i,

    output logic [7:0]           io_out_o,
    output logic                 io_strobe_o,
    input  logic [7:0]           io_in_i,

    output logic                 boot_done_o
);

    typedef enum logic [1:0] {
        StLoadHi = 2'd0,
        StLoadLo = 2'd1,
        StLoadWr = 2'd2,
        StRun    = 2'd3
    } state_e;

    typedef struct packed {
        state_e               st;
        logic [AddrWidth-1:0] ld_addr;
        logic [7:0]           hi;
        logic [7:0]           lo;
        logic                 last;
        logic [7:0]           io_out;
        logic                 io_strobe;
    } regs_t;

    localparam state_e ResetSt = state_e'(BootEn ? StLoadHi : StRun);

    regs_t regs_d, regs_m, regs_q;
    logic  io_hit;
    logic  ld_ready;
    logic  cpu_hold;
    logic [14:0] cpu_rdata;
    logic  unused_rdata_msb;

    // The core bus is 15 bits wide; DQ[15] is only reachable through the loader.
    assign unused_rdata_msb = sram_rdata_i[15];

    assign io_hit = (bus.cpu_adr == IoAddr);

    // Master samples at the close of ph2, slave publishes on ph1: the flop form of the
    // two-phase latch pair, so every register changes only right after ph1 rises.
    always_ff @(negedge ph2_i) begin
        regs_m <= regs_d;
    end

    always_ff @(posedge ph1_i) begin
        regs_q <= regs_m;
    end

    // Next-state: loader FSM and I/O register.
    always_comb begin
        regs_d           = regs_q;
        regs_d.io_strobe = 1'b0;

        unique case (regs_q.st)
            StLoadHi: begin
                if (bus.ld_valid) begin
                    regs_d.hi = bus.ld_data;
                    regs_d.st = StLoadLo;
                end
            end
            StLoadLo: begin
                if (bus.ld_valid) begin
                    regs_d.lo   = bus.ld_data;
                    regs_d.last = bus.ld_last;
                    regs_d.st   = StLoadWr;
                end
            end
            StLoadWr: begin
                // Address is left at the final word when loading ends.
                if (regs_q.last || (regs_q.ld_addr == {AddrWidth{1'b1}})) begin
                    regs_d.st = StRun;
                end else begin
                    regs_d.ld_addr = regs_q.ld_addr + 1'b1;
                    regs_d.st      = StLoadHi;
                end
            end
            StRun: begin
                if (bus.cpu_memwrite && io_hit) begin
                    regs_d.io_out    = bus.cpu_wdata;
                    regs_d.io_strobe = 1'b1;
                end
            end
            default: regs_d.st = ResetSt;
        endcase

        if (reset_i) begin
            regs_d    = '0;
            regs_d.st = ResetSt;
        end
    end

    // Outputs: SRAM controls, read mux and handshake.
    always_comb begin
        sram_ce_n_o     = 1'b1;
        sram_oe_n_o     = 1'b1;
        sram_we_n_o     = 1'b1;
        sram_adr_o      = '0;
        sram_wdata_o    = 16'h0000;
        sram_wdata_oe_o = 1'b0;
        cpu_rdata       = 15'h0000;
        ld_ready        = 1'b0;
        cpu_hold        = 1'b1;

        unique case (regs_q.st)
            StLoadHi, StLoadLo: begin
                ld_ready = ~reset_i;
            end
            StLoadWr: begin
                // A reset landing on the write cycle discards the word instead of storing it.
                if (!reset_i) begin
                    sram_ce_n_o     = 1'b0;
                    sram_we_n_o     = 1'b0;
                    sram_adr_o      = regs_q.ld_addr;
                    sram_wdata_o    = {regs_q.hi, regs_q.lo};
                    sram_wdata_oe_o = 1'b1;
                end
            end
            StRun: begin
                cpu_hold   = 1'b0;
                sram_adr_o = bus.cpu_adr;
                if (io_hit) begin
                    cpu_rdata = {7'b0, io_in_i};
                end else begin
                    cpu_rdata    = sram_rdata_i[14:0];
                    sram_wdata_o = {8'h00, bus.cpu_wdata};
                    if (!reset_i) begin
                        sram_ce_n_o     = 1'b0;
                        sram_oe_n_o     = bus.cpu_memwrite;
                        sram_we_n_o     = ~bus.cpu_memwrite;
                        sram_wdata_oe_o = bus.cpu_memwrite;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdata = cpu_rdata;
    assign bus.cpu_hold  = cpu_hold;
    assign bus.ld_ready  = ld_ready;

    assign io_out_o    = regs_q.io_out;
    assign io_strobe_o = regs_q.io_strobe;
    assign boot_done_o = (regs_q.st == StRun);

endmodule

// File: tb/tb_hmmm_mem_responder.sv
// Directed bench for hmmm_mem_responder: boot-load sequences, a RUN-mode vector table and
// reset/termination corners, checked against hand-computed values and a small SRAM model.
module tb_hmmm_mem_responder;

    logic ph1, ph2, reset;

    hmmm_mem_responder_if #(.AddrWidth(8)) bus ();
    hmmm_mem_responder_if #(.AddrWidth(8)) bus_nb ();

    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe;
    logic [7:0]  sram_adr;
    logic [15:0] sram_wdata, sram_rdata;
    logic [7:0]  io_out, io_in;
    logic        io_strobe, boot_done;

    logic        nb_ce_n, nb_oe_n, nb_we_n, nb_wdata_oe;
    logic [7:0]  nb_adr;
    logic [15:0] nb_wdata;
    logic [15:0] nb_rdata;
    logic [7:0]  nb_io_out;
    logic        nb_io_strobe, nb_boot_done;

    hmmm_mem_responder #(.AddrWidth(8), .IoAddr(8'hFF), .BootEn(1'b1)) u_dut (
        .ph1_i(ph1), .ph2_i(ph2), .reset_i(reset), .bus(bus),
        .sram_ce_n_o(sram_ce_n), .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n),
        .sram_adr_o(sram_adr), .sram_wdata_o(sram_wdata), .sram_wdata_oe_o(sram_wdata_oe),
        .sram_rdata_i(sram_rdata), .io_out_o(io_out), .io_strobe_o(io_strobe),
        .io_in_i(io_in), .boot_done_o(boot_done)
    );

    hmmm_mem_responder #(.AddrWidth(8), .IoAddr(8'hFF), .BootEn(1'b0)) u_dut_nb (
        .ph1_i(ph1), .ph2_i(ph2), .reset_i(reset), .bus(bus_nb),
        .sram_ce_n_o(nb_ce_n), .sram_oe_n_o(nb_oe_n), .sram_we_n_o(nb_we_n),
        .sram_adr_o(nb_adr), .sram_wdata_o(nb_wdata), .sram_wdata_oe_o(nb_wdata_oe),
        .sram_rdata_i(nb_rdata), .io_out_o(nb_io_out), .io_strobe_o(nb_io_strobe),
        .io_in_i(8'h00), .boot_done_o(nb_boot_done)
    );

    // One cycle = ph1 pulse then ph2 pulse, non-overlapping; period 20.
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #5 ph1 = 1'b0;
            #4 ph2 = 1'b1;
            #5 ph2 = 1'b0;
            #5;
        end
    end

    // Async SRAM model: a write is committed at the end of the cycle it is asserted in.
    logic [15:0] mem [256];
    int          wr_count;
    logic        mem_clr;

    always @(negedge ph2) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            wr_count <= 0;
        end else if (!sram_ce_n && !sram_we_n) begin
            mem[sram_adr] <= sram_wdata;
            wr_count      <= wr_count + 1;
        end
    end

    assign sram_rdata = mem[sram_adr];
    assign nb_rdata   = 16'h0000;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic next_cycle();
        @(posedge ph1);
        #2;
    endtask

    task automatic apply_reset(input bit clr);
        reset        = 1'b1;
        mem_clr      = clr;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        next_cycle();
        mem_clr = 1'b0;
        reset   = 1'b0;
    endtask

    // Presents one byte for one cycle; the responder must be ready for it.
    task automatic send(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        #1;
        check("ld_ready_on_byte", bus.ld_ready, 1);
        next_cycle();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic expect_write(input logic [7:0] adr, input logic [15:0] data);
        #1;
        check("load_we_n", sram_we_n, 0);
        check("load_adr", sram_adr, adr);
        check("load_wdata", sram_wdata, data);
        next_cycle();
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [7:0]  wd;
        logic [7:0]  ioin;
        logic [14:0] rdata;
        logic        oe_n;
        logic        we_n;
        logic [15:0] wdata;
        logic        wdata_oe;
        logic [7:0]  io_out;
        logic        strobe;
    } vec_t;

    vec_t vecs[11];

    logic [7:0]  boot_bytes[6];
    logic [15:0] boot_words[3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        logic exp_rdy;
        logic is_wr;

        boot_bytes = '{8'h12, 8'h34, 8'h0A, 8'h05, 8'h70, 8'h2D};
        boot_words = '{16'h1234, 16'h0A05, 16'h702D};

        //            we    adr    wd     ioin   rdata     oe_n  we_n  wdata     woe   io_out s
        vecs[0]  = '{1'b0, 8'h01, 8'h00, 8'h00, 15'h0A05, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00, 15'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 8'h02, 8'h00, 8'h00, 15'h702D, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b1, 8'h10, 8'h2D, 8'h00, 15'h0000, 1'b1, 1'b0, 16'h002D, 1'b1, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 8'h10, 8'h00, 8'h00, 15'h002D, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 8'hFF, 8'h00, 8'h5A, 15'h005A, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b1, 8'hFF, 8'h2D, 8'h00, 15'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, 8'hFF, 8'h3C, 8'h00, 15'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h2D, 1'b1};
        vecs[8]  = '{1'b0, 8'h10, 8'h00, 8'h00, 15'h002D, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h3C, 1'b1};
        vecs[9]  = '{1'b0, 8'h10, 8'h00, 8'h00, 15'h002D, 1'b0, 1'b1, 16'h0000, 1'b0, 8'h3C, 1'b0};
        vecs[10] = '{1'b0, 8'hFF, 8'h00, 8'hA5, 15'h00A5, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h3C, 1'b0};

        reset            = 1'b1;
        mem_clr          = 1'b1;
        io_in            = 8'h00;
        bus.cpu_memwrite = 1'b0;
        bus.cpu_adr      = 8'h00;
        bus.cpu_wdata    = 8'h00;
        bus.ld_valid     = 1'b0;
        bus.ld_data      = 8'h00;
        bus.ld_last      = 1'b0;
        bus_nb.cpu_memwrite = 1'b0;
        bus_nb.cpu_adr      = 8'h00;
        bus_nb.cpu_wdata    = 8'h00;
        bus_nb.ld_valid     = 1'b1;
        bus_nb.ld_data      = 8'h00;
        bus_nb.ld_last      = 1'b0;

        repeat (2) next_cycle();
        mem_clr = 1'b0;
        #1;
        check("rst_ld_ready", bus.ld_ready, 0);
        check("rst_cpu_hold", bus.cpu_hold, 1);
        check("rst_boot_done", boot_done, 0);
        check("rst_we_n", sram_we_n, 1);
        check("rst_io_out", io_out, 0);
        check("rst_io_strobe", io_strobe, 0);
        check("rst_cpu_rdata", bus.cpu_rdata, 0);
        check("nb_boot_done", nb_boot_done, 1);
        check("nb_cpu_hold", bus_nb.cpu_hold, 0);
        check("nb_ld_ready", bus_nb.ld_ready, 0);

        // Boot 3 words with ld_valid held high; ld_last also raised on a hi byte (ignored).
        reset = 1'b0;
        idx   = 0;
        for (int c = 1; c <= 10; c++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = (idx < 6) ? boot_bytes[idx] : 8'hEE;
            bus.ld_last  = (idx == 2) || (idx == 5);
            #1;
            exp_rdy = (c <= 9) && (c % 3 != 0);
            is_wr   = (c <= 9) && (c % 3 == 0);
            check("boot_ld_ready", bus.ld_ready, exp_rdy);
            check("boot_we_n", sram_we_n, !is_wr);
            if (is_wr) begin
                check("boot_adr", sram_adr, c / 3 - 1);
                check("boot_wdata", sram_wdata, boot_words[c/3-1]);
                check("boot_wdata_oe", sram_wdata_oe, 1);
            end
            check("boot_done_seq", boot_done, c == 10);
            check("boot_cpu_hold", bus.cpu_hold, c != 10);
            check("boot_rdata_zero", bus.cpu_rdata, (c == 10) ? 32'h1234 : 32'h0);
            if (exp_rdy) idx++;
            next_cycle();
        end
        for (int i = 0; i < 3; i++) check("boot_mem", mem[i], boot_words[i]);

        // RUN-mode table; stray loader bytes stay asserted throughout.
        bus.ld_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.cpu_memwrite = vecs[i].we;
            bus.cpu_adr      = vecs[i].adr;
            bus.cpu_wdata    = vecs[i].wd;
            io_in            = vecs[i].ioin;
            #1;
            if (!vecs[i].we) check($sformatf("v%0d_rdata", i), bus.cpu_rdata, vecs[i].rdata);
            check($sformatf("v%0d_oe_n", i), sram_oe_n, vecs[i].oe_n);
            check($sformatf("v%0d_we_n", i), sram_we_n, vecs[i].we_n);
            check($sformatf("v%0d_wdata_oe", i), sram_wdata_oe, vecs[i].wdata_oe);
            if (vecs[i].wdata_oe) check($sformatf("v%0d_wdata", i), sram_wdata, vecs[i].wdata);
            if (vecs[i].adr != 8'hFF) check($sformatf("v%0d_adr", i), sram_adr, vecs[i].adr);
            check($sformatf("v%0d_io_out", i), io_out, vecs[i].io_out);
            check($sformatf("v%0d_io_strobe", i), io_strobe, vecs[i].strobe);
            check($sformatf("v%0d_ld_ready", i), bus.ld_ready, 0);
            next_cycle();
        end
        bus.cpu_memwrite = 1'b0;
        bus.cpu_adr      = 8'h00;
        bus.ld_valid     = 1'b0;
        check("io_never_in_sram", mem[255], 16'h0000);
        check("run_write_mem", mem[16], 16'h002D);

        // Reset in LOAD_LO of word 1: hi byte dropped, address back to 0, SRAM retained.
        reset        = 1'b1;
        bus.ld_valid = 1'b1;
        #1;
        check("rst_run_ld_ready", bus.ld_ready, 0);
        next_cycle();
        reset = 1'b0;
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        expect_write(8'h00, 16'hAABB);
        send(8'hCC, 1'b0);
        reset        = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'hDD;
        #1;
        check("midload_ld_ready", bus.ld_ready, 0);
        check("midload_we_n", sram_we_n, 1);
        next_cycle();
        reset        = 1'b0;
        bus.ld_valid = 1'b0;
        send(8'hBE, 1'b0);
        send(8'hEF, 1'b1);
        expect_write(8'h00, 16'hBEEF);
        #1;
        check("reload_boot_done", boot_done, 1);
        check("reload_mem0", mem[0], 16'hBEEF);
        check("reload_mem1_kept", mem[1], 16'h0A05);
        next_cycle();

        // Gapped bytes: idle cycles between bytes must not lose or repeat any.
        apply_reset(1'b1);
        for (int w = 0; w < 3; w++) begin
            send(boot_words[w][15:8], 1'b0);
            #1;
            check("gap_ready_lo", bus.ld_ready, 1);
            check("gap_idle_we_n", sram_we_n, 1);
            next_cycle();
            send(boot_words[w][7:0], w == 2);
            expect_write(w[7:0], boot_words[w]);
            if (w < 2) begin
                #1;
                check("gap_ready_hi", bus.ld_ready, 1);
                next_cycle();
            end
        end
        #1;
        check("gap_boot_done", boot_done, 1);
        check("gap_wr_count", wr_count, 3);
        for (int i = 0; i < 3; i++) check("gap_mem", mem[i], boot_words[i]);
        next_cycle();

        // 256 words without ld_last: terminates after address 0xFF.
        apply_reset(1'b1);
        for (int i = 0; i < 256; i++) begin
            send(~i[7:0], 1'b0);
            send(i[7:0], 1'b0);
            expect_write(i[7:0], {~i[7:0], i[7:0]});
        end
        bus.ld_valid = 1'b1;
        bus.ld_data  = 8'h99;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("full_boot_done", boot_done, 1);
            check("full_ld_ready", bus.ld_ready, 0);
            check("full_we_n", sram_we_n, 1);
            next_cycle();
        end
        bus.ld_valid = 1'b0;
        check("full_wr_count", wr_count, 256);
        check("full_mem_ff", mem[255], 16'h00FF);
        check("full_mem_00", mem[0], 16'hFF00);
        check("nb_still_run", nb_boot_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
